// File: rtl/fp8_dot_accumulator_if.sv
// Stream, adder and result signals of the fp8 dot-product accumulator.
// The master side feeds terms, closes the adder loop and takes results; the slave side is the accumulator.
interface fp8_dot_accumulator_if #(
    parameter int CNT_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [7:0]       add_x;
    logic [7:0]       add_y;
    logic [7:0]       add_z;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] term_cnt;

    modport master (
        output in_valid, in_data, add_z, out_ready,
        input  in_ready, add_x, add_y, out_valid, out_data, term_cnt
    );

    modport slave (
        input  in_valid, in_data, add_z, out_ready,
        output in_ready, add_x, add_y, out_valid, out_data, term_cnt
    );
endinterface

// File: rtl/fp8_dot_accumulator.sv
// Folds N_TERMS fp8 terms into one dot-product element through an external combinational adder.
// Optional macro FP8_ACC_NEGZERO_FLUSH_EN: a -0 (8'h80) result is written to out_data as +0.
module fp8_dot_accumulator #(
    parameter int N_TERMS = 3,
    parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    fp8_dot_accumulator_if.slave bus
);
    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_TERMS);

    state_t           state;
    logic [7:0]       acc;
    logic [7:0]       out_data_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [CNT_W-1:0] term_cnt_r;
    logic             accept;
    logic [7:0]       acc_nxt;

    function automatic logic [7:0] out_fix(input logic [7:0] v);
`ifdef FP8_ACC_NEGZERO_FLUSH_EN
        return (v == 8'h80) ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    assign accept  = bus.in_valid & in_ready_r;
    // The first term of a dot product is loaded raw, never routed through the adder.
    assign acc_nxt = (term_cnt_r == '0) ? bus.in_data : bus.add_z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ACCUM;
            acc         <= 8'h00;
            term_cnt_r  <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_nxt;
                        if (term_cnt_r == LAST_CNT) begin
                            out_data_r  <= out_fix(acc_nxt);
                            term_cnt_r  <= FULL_CNT;
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                        end else begin
                            term_cnt_r <= term_cnt_r + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= ACCUM;
                        acc         <= 8'h00;
                        term_cnt_r  <= '0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.add_x     = acc;
    assign bus.add_y     = bus.in_data;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.term_cnt  = term_cnt_r;
endmodule

// File: tb/tb_fp8_dot_accumulator.sv
// Bench for fp8_dot_accumulator: N=3 and N=1 instances, behavioural fp8 adder and queue scoreboard.
module tb_fp8_dot_accumulator;
    localparam int NA  = 3;
    localparam int CWA = $clog2(NA + 1);
    localparam int NB  = 1;
    localparam int CWB = $clog2(NB + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp8_dot_accumulator_if #(.CNT_W(CWA)) bus_a ();
    fp8_dot_accumulator_if #(.CNT_W(CWB)) bus_b ();

    fp8_dot_accumulator #(.N_TERMS(NA), .CNT_W(CWA)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    fp8_dot_accumulator #(.N_TERMS(NB), .CNT_W(CWB)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    int n_chk = 0;
    int n_bad = 0;

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // fp8 value: bias 3, implicit leading one, exp==0 is subnormal.
    function automatic real fp8_val(input logic [7:0] v);
        real m;
        int  e;
        e = int'(v[6:4]);
        if (e == 0) m = real'(int'(v[3:0])) / 64.0;
        else        m = (16.0 + real'(int'(v[3:0]))) / 16.0 * pow2(e - 3);
        return v[7] ? -m : m;
    endfunction

    function automatic logic [7:0] fp8_enc(input real x);
        real  a;
        int   e;
        int   f;
        logic s;
        s = (x < 0.0);
        a = s ? -x : x;
        if (a == 0.0) return 8'h00;
        e = 0;
        for (int k = 1; k <= 7; k++) if (a >= pow2(k - 3)) e = k;
        if (e == 0) f = int'($floor(a * 64.0));
        else        f = int'($floor((a / pow2(e - 3) - 1.0) * 16.0));
        if (f > 15) f = 15;
        return {s, 3'(e), 4'(f)};
    endfunction

    function automatic logic [7:0] fp8_add(input logic [7:0] a, input logic [7:0] b);
        return fp8_enc(fp8_val(a) + fp8_val(b));
    endfunction

    function automatic logic [7:0] out_fix(input logic [7:0] v);
`ifdef FP8_ACC_NEGZERO_FLUSH_EN
        return (v == 8'h80) ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    assign bus_a.add_z = fp8_add(bus_a.add_x, bus_a.add_y);
    assign bus_b.add_z = fp8_add(bus_b.add_x, bus_b.add_y);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard for the N=3 instance: accepted terms grouped into dot products.
    logic [7:0] grp_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] part;
    bit         mon_en = 1'b0;
    bit         ov_due = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            grp_q.delete();
            exp_q.delete();
            ov_due = 1'b0;
        end else if (mon_en) begin
            if (ov_due) check("ov_latency", 32'(bus_a.out_valid), 32'd1);
            ov_due = 1'b0;
            check("in_ready", 32'(bus_a.in_ready), 32'(!bus_a.out_valid));
            check("add_y", 32'(bus_a.add_y), 32'(bus_a.in_data));
            if (bus_a.out_valid) begin
                check("term_cnt_done", 32'(bus_a.term_cnt), 32'(NA));
                if (exp_q.size() == 0) begin
                    check("early_out_valid", 32'd1, 32'd0);
                end else begin
                    check("out_data", 32'(bus_a.out_data), 32'(out_fix(exp_q[0])));
                    if (bus_a.out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("term_cnt", 32'(bus_a.term_cnt), 32'(grp_q.size()));
                check("add_x", 32'(bus_a.add_x), (grp_q.size() == 0) ? 32'h0 : 32'(part));
                if (bus_a.in_valid) begin
                    part = (grp_q.size() == 0) ? bus_a.in_data : fp8_add(part, bus_a.in_data);
                    grp_q.push_back(bus_a.in_data);
                    if (grp_q.size() == NA) begin
                        exp_q.push_back(part);
                        grp_q.delete();
                        ov_due = 1'b1;
                    end
                end
            end
        end
    end

    task automatic feed(input logic [7:0] t);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = t;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] t;
        reset = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00; bus_b.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_data", 32'(bus_a.out_data), 32'h00);
        check("rst_term_cnt", 32'(bus_a.term_cnt), 32'd0);
        check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
        check("rst_acc", 32'(bus_a.add_x), 32'h00);
        check("rst_b_out_valid", 32'(bus_b.out_valid), 32'd0);
        check("rst_b_in_ready", 32'(bus_b.in_ready), 32'd1);
        mon_en = 1'b1;

        // 1.0 + 1.0 + 1.0 back-to-back
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 8'h30;
        @(posedge clk); #1;
        check("t1_cnt1", 32'(bus_a.term_cnt), 32'd1);
        check("t1_acc1", 32'(bus_a.add_x), 32'h30);
        @(posedge clk); #1;
        check("t1_cnt2", 32'(bus_a.term_cnt), 32'd2);
        check("t1_acc2", 32'(bus_a.add_x), 32'h40);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        check("t1_valid", 32'(bus_a.out_valid), 32'd1);
        check("t1_data", 32'(bus_a.out_data), 32'h48);
        check("t1_busy", 32'(bus_a.in_ready), 32'd0);
        @(posedge clk); #1;
        check("t1_release", 32'(bus_a.out_valid), 32'd0);
        check("t1_cnt_clr", 32'(bus_a.term_cnt), 32'd0);

        // 0 + 1 + 1
        feed(8'h00); check("t2_cnt1", 32'(bus_a.term_cnt), 32'd1);
        feed(8'h30); check("t2_cnt2", 32'(bus_a.term_cnt), 32'd2);
        feed(8'h30); check("t2_cnt3", 32'(bus_a.term_cnt), 32'd3);
        check("t2_data", 32'(bus_a.out_data), 32'h40);
        @(posedge clk); #1;

        // gapped input: no partial emit while stalled
        feed(8'h30);
        repeat (4) begin
            @(posedge clk); #1;
            check("t3_no_early", 32'(bus_a.out_valid), 32'd0);
        end
        feed(8'h30);
        feed(8'h30);
        check("t3_data", 32'(bus_a.out_data), 32'h48);
        @(posedge clk); #1;

        // result held under back-pressure; input refused including the handshake cycle
        bus_a.out_ready = 1'b0;
        feed(8'h30); feed(8'h30); feed(8'h30);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h11;
        repeat (5) begin
            @(posedge clk); #1;
            check("t4_in_ready", 32'(bus_a.in_ready), 32'd0);
            check("t4_hold", 32'(bus_a.out_data), 32'h48);
        end
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_released", 32'(bus_a.out_valid), 32'd0);
        check("t4_not_taken", 32'(bus_a.term_cnt), 32'd0);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        check("t4_taken", 32'(bus_a.term_cnt), 32'd1);
        check("t4_acc", 32'(bus_a.add_x), 32'h11);

        // reset after two accepts discards the partial sum
        feed(8'h30);
        check("t5_cnt2", 32'(bus_a.term_cnt), 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_cnt_clr", 32'(bus_a.term_cnt), 32'd0);
        check("t5_acc_clr", 32'(bus_a.add_x), 32'h00);
        feed(8'h30); feed(8'h30); feed(8'h30);
        check("t5_data", 32'(bus_a.out_data), 32'h48);
        @(posedge clk); #1;

        // reset while a result is pending
        bus_a.out_ready = 1'b0;
        feed(8'h30); feed(8'h30); feed(8'h30);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_drop", 32'(bus_a.out_valid), 32'd0);
        check("t6_ready", 32'(bus_a.in_ready), 32'd1);

        // randomized traffic, back-pressure and occasional resets
        for (int i = 0; i < 1500; i++) begin
            bus_a.in_valid  = ($urandom % 4) != 0;
            bus_a.in_data   = 8'($urandom);
            bus_a.out_ready = ($urandom % 3) != 0;
            reset           = ($urandom % 250) == 0;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("drain", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // N=1: -0 term, then random terms straight through
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 8'h80;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        check("n1_valid", 32'(bus_b.out_valid), 32'd1);
        check("n1_cnt", 32'(bus_b.term_cnt), 32'd1);
`ifdef FP8_ACC_NEGZERO_FLUSH_EN
        check("n1_negzero", 32'(bus_b.out_data), 32'h00);
`else
        check("n1_negzero", 32'(bus_b.out_data), 32'h80);
`endif
        bus_b.out_ready = 1'b1;
        @(posedge clk); #1;
        check("n1_release", 32'(bus_b.out_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            t = 8'($urandom);
            bus_b.out_ready = 1'b0;
            bus_b.in_valid  = 1'b1;
            bus_b.in_data   = t;
            @(posedge clk); #1;
            bus_b.in_valid = 1'b0;
            check("n1_rand_valid", 32'(bus_b.out_valid), 32'd1);
            check("n1_rand_data", 32'(bus_b.out_data), 32'(out_fix(t)));
            bus_b.out_ready = 1'b1;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
